// File: rtl/stack_cpu_pkg.sv
// Shared definitions for the stack CPU: data width, default stack size,
// control-unit opcodes and the pop-count helper used by the stack pointer.
package stack_cpu_pkg;

  localparam int DBITS         = 32;
  localparam int DEFAULT_DEPTH = 16;
  localparam int DEFAULT_PBITS = 4;

  // Opcodes as decoded by the control unit
  localparam logic [5:0] OP_ADD     = 6'b000000;
  localparam logic [5:0] OP_PUSH    = 6'b100000;
  localparam logic [5:0] OP_POP     = 6'b101000;
  localparam logic [5:0] OP_PUSH_PC = 6'b110000;
  localparam logic [5:0] OP_POP_PC  = 6'b111000;

  // read_reg2 alone counts as a single pop, same as read_reg1 alone
  function automatic logic [1:0] pop_count(input logic rd1, input logic rd2);
    logic [1:0] n;
    if (rd1 && rd2) begin
      n = 2'd2;
    end else if (rd1 || rd2) begin
      n = 2'd1;
    end else begin
      n = 2'd0;
    end
    return n;
  endfunction

endpackage

// File: rtl/stack_ptr_ctl.sv
// Stack pointer arithmetic: range checks and next depth for one edge.
// Purely combinational; the owner of the storage registers the results.
module stack_ptr_ctl
  import stack_cpu_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int PBITS = 4
) (
  input  logic [PBITS:0]   count_i,
  input  logic             read_reg1_i,
  input  logic             read_reg2_i,
  input  logic             write_reg_i,
  output logic [PBITS:0]   next_count_o,
  output logic [PBITS-1:0] wr_idx_o,
  output logic             accept_o,
  output logic             ovf_evt_o,
  output logic             unf_evt_o
);

  localparam int CW = PBITS + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [CW-1:0] pops_s;
  logic [CW-1:0] push_s;
  logic [CW-1:0] after_pop_s;
  logic [CW-1:0] after_push_s;

  // Pop-then-push arithmetic in full count width; truncate only for the index
  always_comb begin
    pops_s       = {{(CW-2){1'b0}}, pop_count(read_reg1_i, read_reg2_i)};
    push_s       = {{(CW-1){1'b0}}, write_reg_i};
    after_pop_s  = count_i - pops_s;
    after_push_s = after_pop_s + push_s;
    unf_evt_o    = (pops_s > count_i);
    ovf_evt_o    = !unf_evt_o && (after_push_s > DEPTH_C);
    accept_o     = !unf_evt_o && !ovf_evt_o;
    if (accept_o) begin
      next_count_o = after_push_s;
    end else begin
      next_count_o = count_i;
    end
    // The push lands in the slot just above whatever survives the pops
    wr_idx_o = after_pop_s[PBITS-1:0];
  end

endmodule

// File: rtl/stack_file.sv
// Operand stack for the single-cycle stack CPU. Top two entries are read
// combinationally; pops and an optional push are applied on each edge.
module stack_file #(
  parameter int DBITS = stack_cpu_pkg::DBITS,
  parameter int DEPTH = stack_cpu_pkg::DEFAULT_DEPTH,
  parameter int PBITS = stack_cpu_pkg::DEFAULT_PBITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             read_reg1,
  input  logic             read_reg2,
  input  logic             write_reg,
  input  logic [DBITS-1:0] wdata,
  input  logic             clr_err,
  output logic [DBITS-1:0] rdata1,
  output logic [DBITS-1:0] rdata2,
  output logic [PBITS:0]   count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int CW = PBITS + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [CW-1:0] TWO_C   = CW'(2);

  logic [DBITS-1:0] mem_q [DEPTH];
  logic [CW-1:0]    count_q;
  logic             ovf_q;
  logic             unf_q;
  logic             ovf_d;
  logic             unf_d;

  logic [CW-1:0]    next_count_s;
  logic [PBITS-1:0] wr_idx_s;
  logic             accept_s;
  logic             ovf_evt_s;
  logic             unf_evt_s;
  logic [CW-1:0]    idx1_s;
  logic [CW-1:0]    idx2_s;

  stack_ptr_ctl #(
    .DEPTH(DEPTH),
    .PBITS(PBITS)
  ) u_ptr (
    .count_i      (count_q),
    .read_reg1_i  (read_reg1),
    .read_reg2_i  (read_reg2),
    .write_reg_i  (write_reg),
    .next_count_o (next_count_s),
    .wr_idx_o     (wr_idx_s),
    .accept_o     (accept_s),
    .ovf_evt_o    (ovf_evt_s),
    .unf_evt_o    (unf_evt_s)
  );

  // Sticky error flags: a new error beats a coincident clear
  always_comb begin
    if (ovf_evt_s) begin
      ovf_d = 1'b1;
    end else if (clr_err) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
    if (unf_evt_s) begin
      unf_d = 1'b1;
    end else if (clr_err) begin
      unf_d = 1'b0;
    end else begin
      unf_d = unf_q;
    end
  end

  // Depth and error state; reset discards every entry in one cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= next_count_s;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage is never cleared; only an accepted push writes it
  always_ff @(posedge clk) begin
    if (rst_n && accept_s && write_reg) begin
      mem_q[wr_idx_s] <= wdata;
    end
  end

  // Zero-latency read of the top two entries, zero when not present
  always_comb begin
    idx1_s = count_q - ONE_C;
    idx2_s = count_q - TWO_C;
    if (count_q >= ONE_C) begin
      rdata1 = mem_q[idx1_s[PBITS-1:0]];
    end else begin
      rdata1 = '0;
    end
    if (count_q >= TWO_C) begin
      rdata2 = mem_q[idx2_s[PBITS-1:0]];
    end else begin
      rdata2 = '0;
    end
  end

  assign count     = count_q;
  assign empty     = (count_q == '0);
  assign full      = (count_q == DEPTH_C);
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_stack_file.sv
// Self-checking bench for stack_file with a 4-entry stack. A queue-based
// model tracks the expected contents; every falling edge compares all
// outputs against it, and directed steps pin hand-computed values.
module tb_stack_file;
  import stack_cpu_pkg::*;

  localparam int TB_DBITS = 32;
  localparam int TB_DEPTH = 4;
  localparam int TB_PBITS = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 read_reg1;
  logic                 read_reg2;
  logic                 write_reg;
  logic [TB_DBITS-1:0]  wdata;
  logic                 clr_err;
  logic [TB_DBITS-1:0]  rdata1;
  logic [TB_DBITS-1:0]  rdata2;
  logic [TB_PBITS:0]    count;
  logic                 empty;
  logic                 full;
  logic                 overflow;
  logic                 underflow;

  int checks   = 0;
  int failures = 0;

  int unsigned mq[$];
  bit          m_ovf   = 1'b0;
  bit          m_unf   = 1'b0;
  bit          m_valid = 1'b0;

  stack_file #(
    .DBITS(TB_DBITS),
    .DEPTH(TB_DEPTH),
    .PBITS(TB_PBITS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .read_reg1 (read_reg1),
    .read_reg2 (read_reg2),
    .write_reg (write_reg),
    .wdata     (wdata),
    .clr_err   (clr_err),
    .rdata1    (rdata1),
    .rdata2    (rdata2),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the stack as a queue, updated from the sampled strobes
  always @(posedge clk) begin
    int pops;
    pops = (read_reg1 && read_reg2) ? 2 : ((read_reg1 || read_reg2) ? 1 : 0);
    if (!rst_n) begin
      mq.delete();
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
      m_valid = 1'b1;
    end else begin
      if (clr_err) begin
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end
      if (pops > mq.size()) begin
        m_unf = 1'b1;
      end else if (mq.size() - pops + (write_reg ? 1 : 0) > TB_DEPTH) begin
        m_ovf = 1'b1;
      end else begin
        for (int i = 0; i < pops; i++) void'(mq.pop_back());
        if (write_reg) mq.push_back(wdata);
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    int unsigned e1;
    int unsigned e2;
    if (m_valid) begin
      e1 = (mq.size() >= 1) ? mq[mq.size()-1] : 0;
      e2 = (mq.size() >= 2) ? mq[mq.size()-2] : 0;
      check("m_count", 32'(count), mq.size());
      check("m_empty", 32'(empty), (mq.size() == 0) ? 1 : 0);
      check("m_full", 32'(full), (mq.size() == TB_DEPTH) ? 1 : 0);
      check("m_rdata1", rdata1, e1);
      check("m_rdata2", rdata2, e2);
      check("m_overflow", 32'(overflow), 32'(m_ovf));
      check("m_underflow", 32'(underflow), 32'(m_unf));
    end
  end

  task automatic step(input logic r1, input logic r2, input logic w,
                      input logic [31:0] wd, input logic clr, input logic rst);
    read_reg1 = r1;
    read_reg2 = r2;
    write_reg = w;
    wdata     = wd;
    clr_err   = clr;
    rst_n     = rst;
    @(posedge clk);
    #1;
  endtask

  // Instruction-class view: strobes implied by a control-unit opcode
  task automatic step_op(input logic [5:0] op, input logic [31:0] wd);
    case (op)
      OP_ADD:              step(1'b1, 1'b1, 1'b1, wd, 1'b0, 1'b1);
      OP_PUSH, OP_PUSH_PC: step(1'b0, 1'b0, 1'b1, wd, 1'b0, 1'b1);
      OP_POP, OP_POP_PC:   step(1'b1, 1'b0, 1'b0, wd, 1'b0, 1'b1);
      default:             step(1'b0, 1'b0, 1'b0, wd, 1'b0, 1'b1);
    endcase
  endtask

  initial begin
    read_reg1 = 1'b0; read_reg2 = 1'b0; write_reg = 1'b0;
    wdata = '0; clr_err = 1'b0; rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_flags", {30'd0, overflow, underflow}, 32'd0);

    // 1: two pushes
    step_op(OP_PUSH, 32'd5);
    step_op(OP_PUSH_PC, 32'd7);
    check("t1_count", 32'(count), 32'd2);
    check("t1_rdata1", rdata1, 32'd7);
    check("t1_rdata2", rdata2, 32'd5);
    check("t1_empty", 32'(empty), 32'd0);

    // 2: binary op then pop
    step_op(OP_ADD, 32'd12);
    check("t2_count", 32'(count), 32'd1);
    check("t2_rdata1", rdata1, 32'd12);
    check("t2_rdata2", rdata2, 32'd0);
    step_op(OP_POP, 32'd0);
    check("t2_pop_count", 32'(count), 32'd0);
    check("t2_pop_empty", 32'(empty), 32'd1);
    check("t2_pop_rdata1", rdata1, 32'd0);

    // 3: fill, overflow, then binary op at full depth
    for (int i = 1; i <= 4; i++) step_op(OP_PUSH, 32'(i));
    check("t3_full", 32'(full), 32'd1);
    step_op(OP_PUSH, 32'd9);
    check("t3_ovf", 32'(overflow), 32'd1);
    check("t3_ovf_count", 32'(count), 32'd4);
    check("t3_ovf_rdata1", rdata1, 32'd4);
    step_op(OP_ADD, 32'd7);
    check("t3_bin_count", 32'(count), 32'd3);
    check("t3_bin_rdata1", rdata1, 32'd7);
    check("t3_bin_rdata2", rdata2, 32'd2);

    // 4: underflow on empty, clear, clear racing a new underflow
    for (int i = 0; i < 3; i++) step_op(OP_POP_PC, 32'd0);
    step_op(OP_ADD, 32'd3);
    check("t4_unf", 32'(underflow), 32'd1);
    check("t4_unf_count", 32'(count), 32'd0);
    check("t4_ovf_sticky", 32'(overflow), 32'd1);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    check("t4_clr_unf", 32'(underflow), 32'd0);
    check("t4_clr_ovf", 32'(overflow), 32'd0);
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    check("t4_clr_vs_err", 32'(underflow), 32'd1);

    // 5: reset wins over a coincident push
    step_op(OP_PUSH, 32'd10);
    step_op(OP_PUSH, 32'd20);
    step(1'b0, 1'b0, 1'b1, 32'd30, 1'b0, 1'b0);
    check("t5_rst_count", 32'(count), 32'd0);
    check("t5_rst_empty", 32'(empty), 32'd1);
    check("t5_rst_flags", {30'd0, overflow, underflow}, 32'd0);
    step_op(OP_PUSH, 32'd40);
    check("t5_push_rdata1", rdata1, 32'd40);
    check("t5_push_count", 32'(count), 32'd1);

    // 6: idle holds state
    step_op(OP_POP, 32'd0);
    step_op(OP_PUSH, 32'd6);
    step_op(OP_PUSH, 32'd8);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b1);
      check("t6_idle_count", 32'(count), 32'd2);
      check("t6_idle_rdata1", rdata1, 32'd8);
      check("t6_idle_rdata2", rdata2, 32'd6);
    end

    // read_reg2 alone pops a single entry
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
    check("r2_only_count", 32'(count), 32'd1);
    check("r2_only_rdata1", rdata1, 32'd6);

    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
